// File: rtl/gamma_pkg.sv
// +--------------------------------------------------------------------------+
// | gamma_pkg : state encoding and curve constants shared by gamma_loader    |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

package gamma_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_CHECK = 2'd2,
    ST_READY = 2'd3
  } gamma_state_t;

  localparam int         c_CURVE_LEN = 768;
  localparam int         c_ADDR_W    = 10;

  // Table address bits [9:8] select the colour channel.
  localparam logic [1:0] c_CH_R      = 2'd0;
  localparam logic [1:0] c_CH_G      = 2'd1;
  localparam logic [1:0] c_CH_B      = 2'd2;

endpackage

`default_nettype wire

// File: rtl/gamma_loader.sv
// +--------------------------------------------------------------------------+
// | gamma_loader : streams a 3x256 gamma curve into the gamma table          |
// | Option: GAMMA_LOADER_CHECKSUM_EN adds a trailer-byte checksum check      |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

module gamma_loader
  import gamma_pkg::*;
#(
  parameter int CURVE_LEN = c_CURVE_LEN
) (
  input  logic                clk_sys,
  input  logic                reset_n,
  input  logic                start,
  input  logic                abort,
  input  logic                gamma_req,
  input  logic                s_valid,
  input  logic [7:0]          s_data,
  output logic                s_ready,
  output logic                gamma_wr,
  output logic [c_ADDR_W-1:0] gamma_wr_addr,
  output logic [7:0]          gamma_value,
  output logic                gamma_en,
  output logic                busy,
  output logic                done,
  output logic                error
);

  localparam logic [c_ADDR_W-1:0] c_LAST = c_ADDR_W'(CURVE_LEN - 1);

  gamma_state_t        r_state;
  gamma_state_t        w_next;
  logic [c_ADDR_W-1:0] r_cnt;
  logic [c_ADDR_W-1:0] r_wr_addr;
  logic [7:0]          r_value;
  logic                r_wr;
  logic                r_done;
  logic                r_table_valid;
  logic                r_gamma_en;
  logic                w_busy;
  logic                w_abort;
  logic                w_accept;
  logic                w_last;
  logic                w_load_byte;
  logic                w_to_ready;

`ifdef GAMMA_LOADER_CHECKSUM_EN
  logic [7:0]          r_sum;
  logic                r_error;
  logic                w_sum_ok;
  assign w_sum_ok = (s_data == r_sum);
`endif

  // start outranks both abort and a same-cycle byte
  assign w_abort     = abort & ~start & w_busy;
  assign w_accept    = s_valid & w_busy & ~start & ~abort;
  assign w_last      = (r_cnt == c_LAST);
  assign w_load_byte = w_accept & (r_state == ST_LOAD);
  assign w_to_ready  = (w_next == ST_READY) & (r_state != ST_READY);

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) r_state <= ST_IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    if (start) begin
      w_next = ST_LOAD;
    end else if (w_abort) begin
      w_next = ST_IDLE;
    end else begin
      case (r_state)
        ST_LOAD: begin
          if (w_accept && w_last) begin
`ifdef GAMMA_LOADER_CHECKSUM_EN
            w_next = ST_CHECK;
`else
            w_next = ST_READY;
`endif
          end
        end
`ifdef GAMMA_LOADER_CHECKSUM_EN
        ST_CHECK: begin
          if (w_accept) w_next = w_sum_ok ? ST_READY : ST_IDLE;
        end
`endif
        default: w_next = r_state;
      endcase
    end
  end

  always_comb begin
    w_busy = 1'b0;
    case (r_state)
      ST_LOAD, ST_CHECK: w_busy = 1'b1;
      default:           w_busy = 1'b0;
    endcase
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt         <= '0;
      r_wr          <= 1'b0;
      r_wr_addr     <= '0;
      r_value       <= '0;
      r_done        <= 1'b0;
      r_table_valid <= 1'b0;
      r_gamma_en    <= 1'b0;
    end else begin
      r_wr       <= 1'b0;
      r_done     <= w_to_ready;
      r_gamma_en <= gamma_req & r_table_valid;
      if (start || w_abort) begin
        r_cnt         <= '0;
        r_table_valid <= 1'b0;
      end else begin
        if (w_load_byte) begin
          r_wr      <= 1'b1;
          r_wr_addr <= r_cnt;
          r_value   <= s_data;
          if (!w_last) r_cnt <= r_cnt + 1'b1;
        end
        if (w_to_ready) r_table_valid <= 1'b1;
      end
    end
  end

`ifdef GAMMA_LOADER_CHECKSUM_EN
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      r_sum   <= '0;
      r_error <= 1'b0;
    end else if (start) begin
      r_sum   <= '0;
      r_error <= 1'b0;
    end else if (w_load_byte) begin
      r_sum <= r_sum + s_data;
    end else if (w_accept && (r_state == ST_CHECK) && !w_sum_ok) begin
      r_error <= 1'b1;
    end
  end
  assign error = r_error;
`else
  assign error = 1'b0;
`endif

  assign s_ready       = w_busy;
  assign busy          = w_busy;
  assign gamma_wr      = r_wr;
  assign gamma_wr_addr = r_wr_addr;
  assign gamma_value   = r_value;
  assign gamma_en      = r_gamma_en;
  assign done          = r_done;

endmodule

`default_nettype wire

// File: tb/tb_gamma_loader.sv
// +--------------------------------------------------------------------------+
// | tb_gamma_loader : self-checking bench for gamma_loader                   |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_gamma_loader;
  import gamma_pkg::*;

  localparam int N = 768;

  logic       clk_sys   = 1'b0;
  logic       reset_n   = 1'b0;
  logic       start     = 1'b0;
  logic       abort     = 1'b0;
  logic       gamma_req = 1'b0;
  logic       s_valid   = 1'b0;
  logic [7:0] s_data    = 8'h00;
  logic       s_ready;
  logic       gamma_wr;
  logic [9:0] gamma_wr_addr;
  logic [7:0] gamma_value;
  logic       gamma_en;
  logic       busy;
  logic       done;
  logic       error;

  always #5 clk_sys = ~clk_sys;

  gamma_loader #(.CURVE_LEN(N)) dut (
    .clk_sys(clk_sys), .reset_n(reset_n), .start(start), .abort(abort),
    .gamma_req(gamma_req), .s_valid(s_valid), .s_data(s_data),
    .s_ready(s_ready), .gamma_wr(gamma_wr), .gamma_wr_addr(gamma_wr_addr),
    .gamma_value(gamma_value), .gamma_en(gamma_en), .busy(busy),
    .done(done), .error(error)
  );

  int          n_tests = 0;
  int          n_fail  = 0;
  int          done_cnt = 0;
  bit          stalled = 1'b0;
  bit          alt = 1'b0;
  logic [17:0] wq[$];
  logic [17:0] eq[$];
  logic [7:0]  data_arr[N];

  // Write and done observer, sampled mid-cycle
  always @(negedge clk_sys) begin
    if (gamma_wr) wq.push_back({gamma_wr_addr, gamma_value});
    if (done) done_cnt++;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_sys);
    #1;
    alt = ~alt;
  endtask

  function automatic logic [31:0] outs_packed();
    return {8'h00, s_ready, gamma_wr, gamma_wr_addr, gamma_value, gamma_en, busy, done, error};
  endfunction

  function automatic logic [7:0] sum_data(input int n);
    logic [7:0] s = 8'h00;
    for (int i = 0; i < n; i++) s = s + data_arr[i];
    return s;
  endfunction

  task automatic begin_scenario();
    wq.delete();
    eq.delete();
    done_cnt = 0;
    stalled  = 1'b0;
  endtask

  task automatic add_expected(input int n);
    for (int i = 0; i < n; i++) eq.push_back({10'(i), data_arr[i]});
  endtask

  task automatic check_seq(input string name);
    int bad = -1;
    n_tests++;
    for (int i = 0; i < eq.size() && i < wq.size(); i++)
      if (wq[i] !== eq[i]) begin bad = i; break; end
    if (bad < 0 && wq.size() != eq.size())
      bad = (wq.size() < eq.size()) ? wq.size() : eq.size();
    if (bad >= 0) begin
      n_fail++;
      $display("FAIL %s: write #%0d got %0h expected %0h (writes %0d, expected %0d)", name, bad,
               (bad < wq.size()) ? wq[bad] : 18'h3ffff, (bad < eq.size()) ? eq[bad] : 18'h3ffff,
               wq.size(), eq.size());
    end
  endtask

  // Present one byte until it is accepted; vmode 0 always valid, 1 alternate, 2 random
  task automatic push_byte(input logic [7:0] b, input int vmode);
    int   waitc = 0;
    logic v;
    logic acc;
    if (stalled) return;
    forever begin
      v = (vmode == 0) ? 1'b1 : (vmode == 1) ? alt : ($urandom_range(0, 3) != 0);
      s_valid = v;
      s_data  = v ? b : 8'($urandom);
      acc = v && s_ready;
      tick();
      if (acc) break;
      waitc++;
      if (waitc > 50) begin
        n_tests++;
        n_fail++;
        stalled = 1'b1;
        $display("FAIL handshake: byte not accepted within 50 cycles");
        break;
      end
    end
    s_valid = 1'b0;
  endtask

  task automatic start_pulse(input bit with_byte);
    start   = 1'b1;
    s_valid = with_byte;
    s_data  = 8'($urandom);
    tick();
    start   = 1'b0;
    s_valid = 1'b0;
  endtask

  task automatic send_bytes(input int n, input int vmode);
    for (int i = 0; i < n; i++) push_byte(data_arr[i], vmode);
  endtask

  task automatic send_full(input int vmode, input bit good_trailer);
    send_bytes(N, vmode);
`ifdef GAMMA_LOADER_CHECKSUM_EN
    push_byte(good_trailer ? sum_data(N) : sum_data(N) + 8'h01, vmode);
`else
    if (!good_trailer) $display("note: trailer ignored in this build");
`endif
  endtask

  task automatic fill_ramp();
    for (int i = 0; i < N; i++) data_arr[i] = 8'(i);
  endtask

  task automatic fill_const(input logic [7:0] b);
    for (int i = 0; i < N; i++) data_arr[i] = b;
  endtask

  // Bytes offered while not loading must be ignored
  task automatic idle_noise(input int cycles);
    s_valid = 1'b1;
    for (int i = 0; i < cycles; i++) begin
      s_data = 8'($urandom);
      tick();
    end
    s_valid = 1'b0;
  endtask

  typedef struct {
    string name;
    int    evt;        // 0 full load, 1 abort after cut, 2 restart after cut
    int    cut;
    int    vmode;
    bit    greq;
    int    exp_writes;
    int    exp_last;
    int    exp_done;
    bit    exp_busy;
    bit    exp_en;
  } vec_t;

  vec_t vt[5];

  initial begin
    int  wc;
    bit  full;
    bit  good;
    int  cut;
    bit  greq;

    vt[0] = '{"full_stream",   0, 0,   0, 1'b1, 768, 767, 1, 1'b0, 1'b1};
    vt[1] = '{"abort_300",     1, 300, 0, 1'b1, 300, 299, 0, 1'b0, 1'b0};
    vt[2] = '{"full_toggle",   0, 0,   1, 1'b1, 768, 767, 1, 1'b0, 1'b1};
    vt[3] = '{"full_req_off",  0, 0,   0, 1'b0, 768, 767, 1, 1'b0, 1'b0};
    vt[4] = '{"restart_100",   2, 100, 0, 1'b1, 868, 767, 1, 1'b0, 1'b1};

    // Reset state
    repeat (3) @(posedge clk_sys);
    #1;
    check("reset_outputs", outs_packed(), 32'h0);
    reset_n = 1'b1;
    tick();
    check("idle_after_reset", outs_packed(), 32'h0);

    // Table-driven loads
    for (int k = 0; k < 5; k++) begin
      begin_scenario();
      fill_ramp();
      gamma_req = vt[k].greq;
      start_pulse(1'b0);
      case (vt[k].evt)
        0: begin
          send_full(vt[k].vmode, 1'b1);
          add_expected(N);
        end
        1: begin
          send_bytes(vt[k].cut, vt[k].vmode);
          abort   = 1'b1;
          s_valid = 1'b1;
          s_data  = data_arr[vt[k].cut];
          tick();
          abort   = 1'b0;
          s_valid = 1'b0;
          add_expected(vt[k].cut);
        end
        default: begin
          send_bytes(vt[k].cut, vt[k].vmode);
          start_pulse(1'b1);
          send_full(vt[k].vmode, 1'b1);
          add_expected(vt[k].cut);
          add_expected(N);
        end
      endcase
      idle_noise(5);
      repeat (3) tick();
      check_seq({vt[k].name, "_seq"});
      check({vt[k].name, "_writes"}, wq.size(), vt[k].exp_writes);
      check({vt[k].name, "_last_addr"}, (wq.size() > 0) ? {22'h0, wq[wq.size()-1][17:8]} : 32'hffffffff,
            vt[k].exp_last);
      check({vt[k].name, "_done"}, done_cnt, vt[k].exp_done);
      check({vt[k].name, "_busy"}, busy, vt[k].exp_busy);
      check({vt[k].name, "_gamma_en"}, gamma_en, vt[k].exp_en);
      check({vt[k].name, "_error"}, error, 0);
    end

    // gamma_en follows gamma_req one cycle late while the table is valid
    gamma_req = 1'b0;
    check("en_lat_hold", gamma_en, 1);
    tick();
    check("en_lat_off", gamma_en, 0);
    gamma_req = 1'b1;
    tick();
    check("en_lat_on", gamma_en, 1);
    check("done_low_in_ready", done, 0);

    // Asynchronous reset in the middle of a load
    begin_scenario();
    fill_ramp();
    start_pulse(1'b0);
    send_bytes(500, 0);
    s_valid = 1'b1;
    s_data  = data_arr[500];
    #2;
    reset_n = 1'b0;
    #1;
    check("reset_midload_outputs", outs_packed(), 32'h0);
    repeat (3) tick();
    check("reset_held_outputs", outs_packed(), 32'h0);
    wc = wq.size();
    reset_n = 1'b1;
    idle_noise(20);
    check("reset_no_write_after", wq.size(), wc);
    check("reset_not_busy", busy, 0);

    // Recovery after reset restarts at address 0
    begin_scenario();
    start_pulse(1'b0);
    send_bytes(5, 0);
    tick();
    add_expected(5);
    check_seq("recover_seq");
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("recover_abort_busy", busy, 0);

`ifdef GAMMA_LOADER_CHECKSUM_EN
    // All-ones curve: 768 mod 256 = 0, so trailer 0x00 is correct
    begin_scenario();
    fill_const(8'h01);
    gamma_req = 1'b1;
    start_pulse(1'b0);
    send_bytes(N, 0);
    push_byte(8'h00, 0);
    repeat (3) tick();
    add_expected(N);
    check_seq("cks_good_seq");
    check("cks_good_done", done_cnt, 1);
    check("cks_good_en", gamma_en, 1);
    check("cks_good_error", error, 0);

    begin_scenario();
    start_pulse(1'b0);
    send_bytes(N, 0);
    push_byte(8'h01, 0);
    repeat (3) tick();
    add_expected(N);
    check_seq("cks_bad_seq");
    check("cks_bad_done", done_cnt, 0);
    check("cks_bad_en", gamma_en, 0);
    check("cks_bad_error", error, 1);
    check("cks_bad_busy", busy, 0);
    start_pulse(1'b0);
    check("cks_error_cleared", error, 0);
    abort = 1'b1;
    tick();
    abort = 1'b0;
`endif

    // Randomized loads against a whole-transaction reference model
    for (int it = 0; it < 4; it++) begin
      begin_scenario();
      for (int i = 0; i < N; i++) data_arr[i] = 8'($urandom);
      greq = 1'($urandom_range(0, 1));
      full = (it % 2 == 0) || ($urandom_range(0, 1) == 1);
      good = (it != 2);
      cut  = full ? N : int'($urandom_range(1, N - 1));
      gamma_req = greq;
      start_pulse(1'b0);
      if (full) begin
        send_full(2, good);
      end else begin
        send_bytes(cut, 2);
        abort = 1'b1;
        tick();
        abort = 1'b0;
      end
      idle_noise(4);
      repeat (3) tick();
`ifndef GAMMA_LOADER_CHECKSUM_EN
      good = 1'b1;
`endif
      add_expected(cut);
      check_seq("rand_seq");
      check("rand_done", done_cnt, (full && good) ? 1 : 0);
      check("rand_gamma_en", gamma_en, greq && full && good);
      check("rand_error", error, full && !good);
      check("rand_busy", busy, 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/gamma_loader.md
GAMMA_LOADER -- requirements
Module: gamma_loader

Interface
REQ-001 SHALL: parameter CURVE_LEN, default 768, number of curve bytes per load (3 x 256, R then G then B).
REQ-002 SHALL: clk_sys  in  1  single clock; all logic on its rising edge.
REQ-003 SHALL: reset_n  in  1  reset, asynchronous and active-low.
REQ-004 SHALL: start  in  1  one-cycle pulse; begins a new curve load.
REQ-005 SHALL: abort  in  1  one-cycle pulse; cancels the load in progress.
REQ-006 SHALL: gamma_req  in  1  user gamma on/off setting.
REQ-007 SHALL: s_valid  in  1  curve byte present.
REQ-008 SHALL: s_data  in  8  curve byte.
REQ-009 SHALL: s_ready  out  1  loader accepts byte this cycle.
REQ-010 SHALL: gamma_wr  out  1  table write strobe.
REQ-011 SHALL: gamma_wr_addr  out  10  table write address, bits [9:8] select channel.
REQ-012 SHALL: gamma_value  out  8  table write data.
REQ-013 SHALL: gamma_en  out  1  correction enable to the gamma stage.
REQ-014 SHALL: busy  out  1  high in LOAD and CHECK.
REQ-015 SHALL: done  out  1  one-cycle pulse on successful load completion.
REQ-016 SHALL: error  out  1  sticky checksum-failure flag, cleared by start.

Function
REQ-017 SHALL: states IDLE, LOAD, CHECK, READY.
REQ-018 SHALL: IDLE->LOAD on start; byte counter := 0, sum := 0, table_valid := 0, error := 0.
REQ-019 SHALL: s_ready = 1 only in LOAD and CHECK; a byte is accepted when s_valid & s_ready.
REQ-020 SHALL: accepted LOAD byte n produces gamma_wr=1, gamma_wr_addr=n, gamma_value=byte on the next cycle (latency 1); gamma_wr=0 otherwise.
REQ-021 SHALL: counter and sum (8-bit, modulo 256) advance only on acceptance; s_valid low stalls without side effects.
REQ-022 SHALL: acceptance of byte CURVE_LEN-1 leaves LOAD (to CHECK or READY per Configuration); counter never wraps.
REQ-023 SHALL: READY sets table_valid := 1 and pulses done for exactly one cycle on entry.
REQ-024 SHALL: gamma_en = gamma_req & table_valid, registered (1-cycle latency from either input).
REQ-025 SHALL: start in any state, including LOAD/CHECK, restarts per REQ-018; start wins over a same-cycle accepted byte (byte discarded, no write).
REQ-026 SHALL: abort in LOAD/CHECK -> IDLE, table_valid := 0, no further writes; abort in IDLE/READY ignored; start and abort together -> start wins.
REQ-027 SHALL: READY remains until start; bytes presented in IDLE/READY are not accepted.

Reset
REQ-028 SHALL: reset_n low asynchronously forces IDLE, counter 0, sum 0, table_valid 0, s_ready 0, gamma_wr 0, gamma_wr_addr 0, gamma_value 0, gamma_en 0, busy 0, done 0, error 0.
REQ-029 SHALL: reset mid-load leaves no pending write strobe after release.

Configuration
REQ-030 SHALL: macro GAMMA_LOADER_CHECKSUM_EN defined: after byte CURVE_LEN-1 enter CHECK, accept one trailer byte; trailer == sum -> READY; mismatch -> IDLE, error := 1, table_valid 0; trailer produces no table write.
REQ-031 SHALL: macro undefined: after byte CURVE_LEN-1 go directly to READY; no CHECK state, no sum logic, error tied 0.

Structure
REQ-032 SHALL: shared package gamma_pkg holds state enum, CURVE_LEN default, channel-select constants (R=0, G=1, B=2).
REQ-033 SHALL: single flat module, no sub-modules.

Verification
REQ-034 SHALL: start, 768 bytes value = addr[7:0], s_valid always 1 -> 768 writes addr 0..767, done pulse once, gamma_en=1 with gamma_req=1.
REQ-035 SHALL: same load with s_valid toggling every other cycle -> identical write sequence, no duplicate or skipped addresses.
REQ-036 SHALL: abort after byte 300 -> no write beyond addr 299, busy=0, gamma_en=0.
REQ-037 SHALL: start reissued after byte 100 -> next write at addr 0, full 768 writes, done once.
REQ-038 SHALL: with GAMMA_LOADER_CHECKSUM_EN, all bytes 0x01, trailer 0x00 -> READY; trailer 0x01 -> error=1, gamma_en=0.
REQ-039 SHALL: reset_n low during LOAD at byte 500 -> all outputs at reset values in same cycle, gamma_wr never asserted afterwards until new start.
